// File: rtl/alu_muldiv_seq_if.sv
// Request/result and ALU-drive bundle for the multiply/divide sequencer.
`default_nettype none

interface alu_muldiv_seq_if;
    logic        start;
    logic        op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [3:0]  aluf;
    logic        alumode;
    logic        cin0;
    logic [31:0] a_out;
    logic [31:0] m_out;
    logic [31:0] alu;
    logic        alu_cout;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;

    modport master (
        output start, op, opa, opb, alu, alu_cout,
        input  aluf, alumode, cin0, a_out, m_out, busy, done, hi, lo, err
    );

    modport slave (
        input  start, op, opa, opb, alu, alu_cout,
        output aluf, alumode, cin0, a_out, m_out, busy, done, hi, lo, err
    );
endinterface

`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
// ============================================================================
// alu_muldiv_seq : drives a 32-bit 74S181 datapath through 32 shift-add /
//                  restoring-subtract steps for unsigned mul and div.
// Revision 1.0
// ============================================================================
`default_nettype none

module alu_muldiv_seq #(
    parameter logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_muldiv_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] acc;
    logic [31:0] q;
    logic [31:0] b;
    logic [4:0]  cnt;
    logic        opr;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [3:0]  aluf;
    logic        alumode;
    logic        cin0;
    logic [31:0] a_drv;
    logic [31:0] m_drv;
    logic [31:0] acc_nxt;
    logic [31:0] q_nxt;
    logic        div_ok;

    always_comb begin
        aluf    = 4'b1111;
        alumode = 1'b1;
        cin0    = 1'b0;
        a_drv   = 32'd0;
        m_drv   = 32'd0;
        if (state == RUN) begin
            a_drv = b;
            if (opr) begin
                m_drv   = {acc[30:0], q[31]};
                aluf    = 4'b0110;
                alumode = 1'b0;
                cin0    = 1'b1;
            end else begin
                m_drv = acc;
                if (q[0]) begin
                    aluf    = 4'b1001;
                    alumode = 1'b0;
                end
            end
        end
    end

    // acc[31] set means the shifted partial remainder is 33 bits wide, so the
    // subtract always fits even when the ALU reports a borrow.
    assign div_ok = acc[31] | bus.alu_cout;

    always_comb begin
        acc_nxt = acc;
        q_nxt   = q;
        // err is only set here on a divide-by-zero: the step then just waits
        if (!err) begin
            if (opr) begin
                acc_nxt = div_ok ? bus.alu : m_drv;
                q_nxt   = {q[30:0], div_ok};
            end else begin
                acc_nxt = {q[0] & bus.alu_cout, bus.alu[31:1]};
                q_nxt   = {bus.alu[0], q[31:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            acc   <= 32'd0;
            q     <= 32'd0;
            b     <= 32'd0;
            cnt   <= 5'd0;
            opr   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        opr   <= bus.op;
                        b     <= bus.opb;
                        state <= RUN;
                        // divide-by-zero takes a single idle step so done
                        // still lands two edges after the request
                        if (bus.op && (bus.opb == 32'd0)) begin
                            acc <= bus.opa;
                            q   <= DIV0_QUOT;
                            err <= 1'b1;
                            cnt <= 5'd0;
                        end else begin
                            acc  <= 32'd0;
                            q    <= bus.opa;
                            err  <= 1'b0;
                            cnt  <= 5'd31;
                            busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= acc_nxt;
                        lo    <= q_nxt;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.aluf    = aluf;
    assign bus.alumode = alumode;
    assign bus.cin0    = cin0;
    assign bus.a_out   = a_drv;
    assign bus.m_out   = m_drv;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.err     = err;
    assign bus.hi      = hi;
    assign bus.lo      = lo;

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: behavioural 74S181 subset plus arithmetic reference.
`default_nettype none

module tb_alu_muldiv_seq;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    alu_muldiv_seq_if bus ();

    alu_muldiv_seq #(.DIV0_QUOT(32'hFFFF_FFFF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 181 with M bus on the A input: pass A, A plus B plus Cn, A minus B minus 1 plus Cn
    always_comb begin
        logic [32:0] sum;
        sum = 33'd0;
        case ({bus.alumode, bus.aluf})
            5'b1_1111: sum = {1'b0, bus.m_out};
            5'b0_1001: sum = {1'b0, bus.m_out} + {1'b0, bus.a_out} + {32'd0, bus.cin0};
            5'b0_0110: sum = {1'b0, bus.m_out} + {1'b0, ~bus.a_out} + {32'd0, bus.cin0};
            default:   sum = 33'd0;
        endcase
        bus.alu      = sum[31:0];
        bus.alu_cout = bus.alumode ? 1'b0 : sum[32];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {err, hi, lo}
    function automatic logic [64:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        if (!o) begin
            p = 64'(a) * 64'(b);
            return {1'b0, p};
        end
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
    endfunction

    task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.opa   = a;
        bus.opb   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // called 1 ns after the accepting edge; edges counts edges after it
    task automatic wait_done(output int edges, output int busy_cyc);
        edges    = 0;
        busy_cyc = 0;
        while (!bus.done && edges < 100) begin
            if (bus.busy) busy_cyc++;
            @(posedge clk);
            #1;
            edges++;
        end
        if (!bus.done) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b);
        int          edges;
        int          bc;
        logic [64:0] exp;
        exp = model(o, a, b);
        issue(o, a, b);
        wait_done(edges, bc);
        check({tag, "_latency"}, 64'(edges + 1), exp[64] ? 64'd2 : 64'd33);
        check({tag, "_busy"}, 64'(bc), exp[64] ? 64'd0 : 64'd32);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp[63:32]));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp[31:0]));
        check({tag, "_err"}, 64'(bus.err), 64'(exp[64]));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int          edges;
        int          bc;
        logic [31:0] pa;
        logic [31:0] pb;
        logic        o;
        logic [31:0] a;
        logic [31:0] b;

        checks    = 0;
        errors    = 0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.opa   = 32'd0;
        bus.opb   = 32'd0;
        reset_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        do_op("mul3x5", 1'b0, 32'd3, 32'd5);
        do_op("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("div100_7", 1'b1, 32'd100, 32'd7);
        do_op("divwide", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
        do_op("div0", 1'b1, 32'd1234, 32'd0);
        do_op("errclr", 1'b0, 32'd9, 32'd11);

        // start held high with changing operands throughout a 6x7 multiply
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.opa   = 32'd6;
        bus.opb   = 32'd7;
        @(posedge clk);
        #1;
        edges = 0;
        while (!bus.done && edges < 100) begin
            @(negedge clk);
            bus.op  = 1'($urandom);
            bus.opa = $urandom;
            bus.opb = $urandom;
            @(posedge clk);
            #1;
            edges++;
        end
        check("spam_latency", 64'(edges + 1), 64'd33);
        check("spam_result", {bus.hi, bus.lo}, 64'd42);
        @(negedge clk);
        bus.op  = 1'b0;
        bus.opa = $urandom;
        bus.opb = $urandom;
        @(posedge clk);
        #1;
        check("spam_fin_ignored", 64'(bus.busy), 64'd0);
        pa = $urandom;
        pb = $urandom;
        @(negedge clk);
        bus.opa = pa;
        bus.opb = pb;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(edges, bc);
        check("spam_next_busy", 64'(bc), 64'd32);
        check("spam_next_result", {bus.hi, bus.lo}, 64'(pa) * 64'(pb));
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'($urandom_range(0, 15));
                1:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_op($sformatf("rnd%0d", i), o, a, b);
        end

        // reset in the middle of a divide
        issue(1'b1, 32'hDEAD_BEEF, 32'd13);
        repeat (9) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
        check("midrst_err", 64'(bus.err), 64'd0);
        edges = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done) edges++;
        end
        check("midrst_nodone", 64'(edges), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_op("postrst", 1'b1, 32'hDEAD_BEEF, 32'd13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
